axis_moving_average: RTL and testbench
======================================

AXIS_MOVING_AVERAGE -- requirements
Module: axis_moving_average

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 1: bus width in bytes; sample width DW = BUS_WIDTH*8.
REQ-002 SHALL have parameter WEIGHT, default 8: number of samples averaged; power of two, >= 2; any other value SHALL stop elaboration.
REQ-003 SHALL have port aclk, input, 1: the single clock; all logic rising-edge.
REQ-004 SHALL have port arstn, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port s_axis_tdata, input, DW: input sample, unsigned.
REQ-006 SHALL have port s_axis_tvalid, input, 1: input sample valid.
REQ-007 SHALL have port s_axis_tready, output, 1: block accepts an input sample.
REQ-008 SHALL have port m_axis_tdata, output, DW: averaged result, unsigned.
REQ-009 SHALL have port m_axis_tvalid, output, 1: result valid.
REQ-010 SHALL have port m_axis_tready, input, 1: downstream accepts the result.

Function
REQ-011 SHALL keep a history of the last WEIGHT accepted samples, DW bits each, all zero after reset.
REQ-012 SHALL keep a running sum of width DW+log2(WEIGHT), so it never overflows.
REQ-013 An input is accepted in a cycle where s_axis_tvalid and s_axis_tready are both 1.
REQ-014 On accept: sum_next = sum + new - oldest; the new sample enters the history; the oldest sample is discarded.
REQ-015 On accept: m_axis_tdata <= sum_next >> log2(WEIGHT), which is truncating division with no rounding.
REQ-016 On accept: m_axis_tvalid <= 1, so the result is registered with a latency of 1 clock after the accept edge.
REQ-017 Before WEIGHT samples have been accepted, the missing history entries SHALL count as zero; outputs SHALL still be produced, one per input.
REQ-018 Exactly one output beat SHALL be produced per accepted input; no outputs are dropped or duplicated.
REQ-019 s_axis_tready = m_axis_tready OR NOT m_axis_tvalid, as combinational logic.
REQ-020 When m_axis_tvalid=1 and m_axis_tready=0: m_axis_tdata and m_axis_tvalid SHALL hold; no input is accepted.
REQ-021 When an output is taken (m_axis_tvalid and m_axis_tready) and no input is accepted in that cycle: m_axis_tvalid <= 0.
REQ-022 A simultaneous output take and input accept SHALL give back-to-back outputs with no bubble, sustaining 1 sample per clock.
REQ-023 With no accept, the history and sum SHALL NOT change, regardless of s_axis_tdata.

Reset
REQ-024 While arstn=0: m_axis_tvalid=0, m_axis_tdata=0, sum=0, all history entries=0; this SHALL take effect immediately, independent of aclk.
REQ-025 s_axis_tready during reset SHALL follow REQ-019, and is therefore 1.
REQ-026 Reset asserted mid-stream SHALL discard the pending output and all history; the first output after release SHALL be computed as if the stream were new.

Verification (BUS_WIDTH=2, WEIGHT=8, m_axis_tready=1 unless stated)
REQ-027 Step test: 10 samples of 0x0800 -> outputs 0x0100, 0x0200, 0x0300, 0x0400, 0x0500, 0x0600, 0x0700, 0x0800, 0x0800, 0x0800.
REQ-028 Impulse test: 0x0800 followed by 9 samples of 0x0000 -> outputs 0x0100 eight times, then 0x0000, 0x0000.
REQ-029 Full-scale test: 9 samples of 0xFFFF -> 8th and 9th outputs are 0xFFFF, with no wrap; the 1st output is 0x1FFF.
REQ-030 Backpressure test: m_axis_tready held 0 for 5 clocks with output valid -> s_axis_tready=0, m_axis_tdata stable; on release, the sequence is unchanged versus the REQ-027 result.
REQ-031 Gap test: s_axis_tvalid toggled on alternate cycles, with s_axis_tdata driven to garbage while invalid -> output sequence identical to REQ-027.
REQ-032 Reset test: arstn pulsed low after 4 step samples -> m_axis_tvalid drops at once; the next 0x0800 input yields 0x0100.

Source files
------------

// File: rtl/axis_moving_average.sv
// Streaming moving average over the last WEIGHT accepted samples, AXI-Stream in/out.
// The running sum is kept one log2(WEIGHT) wider than a sample, so it never overflows.
module axis_moving_average #(
   parameter int BUS_WIDTH = 1,
   parameter int WEIGHT    = 8
) (
   input  logic                   aclk,
   input  logic                   arstn,
   input  logic [BUS_WIDTH*8-1:0] s_axis_tdata,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready,
   output logic [BUS_WIDTH*8-1:0] m_axis_tdata,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready
);
   localparam int DW = BUS_WIDTH * 8;
   localparam int LW = (WEIGHT > 1) ? $clog2(WEIGHT) : 1;
   localparam int SW = DW + LW;

   generate
      if ((WEIGHT < 2) || ((WEIGHT & (WEIGHT - 1)) != 0)) begin : g_bad_weight
         $error("axis_moving_average: WEIGHT must be a power of two and at least 2");
      end
      if (BUS_WIDTH < 1) begin : g_bad_width
         $error("axis_moving_average: BUS_WIDTH must be at least 1");
      end
   endgenerate

   logic [DW-1:0] hist_r [WEIGHT];
   logic [LW-1:0] wr_ptr_r;
   logic [SW-1:0] sum_r;
   logic [DW-1:0] m_data_r;
   logic          m_valid_r;

   logic [SW-1:0] sum_next_s;
   logic [DW-1:0] oldest_s;
   logic          s_ready_s;
   logic          accept_s;
   logic          take_s;

   // Handshake decode and next running sum; the slot at wr_ptr_r holds the oldest sample.
   always_comb begin
      s_ready_s  = m_axis_tready | ~m_valid_r;
      accept_s   = s_axis_tvalid & s_ready_s;
      take_s     = m_valid_r & m_axis_tready;
      oldest_s   = hist_r[wr_ptr_r];
      sum_next_s = sum_r + {{LW{1'b0}}, s_axis_tdata} - {{LW{1'b0}}, oldest_s};
   end

   // Circular history: the new sample overwrites the oldest one, pointer wraps naturally.
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         for (int i = 0; i < WEIGHT; i++) begin
            hist_r[i] <= '0;
         end
         wr_ptr_r <= '0;
      end else if (accept_s) begin
         hist_r[wr_ptr_r] <= s_axis_tdata;
         wr_ptr_r         <= wr_ptr_r + LW'(1);
      end else begin
         wr_ptr_r <= wr_ptr_r;
      end
   end

   // Running sum of the history contents.
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         sum_r <= '0;
      end else if (accept_s) begin
         sum_r <= sum_next_s;
      end else begin
         sum_r <= sum_r;
      end
   end

   // Output register: load on accept, clear valid on a take without a new accept, else hold.
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         m_data_r  <= '0;
         m_valid_r <= 1'b0;
      end else if (accept_s) begin
         m_data_r  <= sum_next_s[SW-1:LW];
         m_valid_r <= 1'b1;
      end else if (take_s) begin
         m_data_r  <= m_data_r;
         m_valid_r <= 1'b0;
      end else begin
         m_data_r  <= m_data_r;
         m_valid_r <= m_valid_r;
      end
   end

   assign s_axis_tready = s_ready_s;
   assign m_axis_tdata  = m_data_r;
   assign m_axis_tvalid = m_valid_r;

endmodule

// File: tb/tb_axis_moving_average.sv
// Scoreboard bench for axis_moving_average (BUS_WIDTH=2, WEIGHT=8): a plain
// last-8-samples averaging model feeds an expectation queue popped on each output beat.
module tb_axis_moving_average;
   logic        aclk;
   logic        arstn;
   logic [15:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] m_data;
   logic        m_valid;
   logic        m_ready;

   int vectors = 0;
   int fails   = 0;

   logic [15:0] exp_q[$];
   logic [15:0] hist_m[8];
   logic [15:0] step_tbl[10] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500,
                                 16'h0600, 16'h0700, 16'h0800, 16'h0800, 16'h0800};

   axis_moving_average #(.BUS_WIDTH(2), .WEIGHT(8)) dut (
      .aclk          (aclk),
      .arstn         (arstn),
      .s_axis_tdata  (s_data),
      .s_axis_tvalid (s_valid),
      .s_axis_tready (s_ready),
      .m_axis_tdata  (m_data),
      .m_axis_tvalid (m_valid),
      .m_axis_tready (m_ready)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   // Reference: sum of the last eight accepted samples (zeros before), divided by eight.
   task automatic model_push(input logic [15:0] d);
      int unsigned s;
      s = 0;
      for (int i = 7; i > 0; i--) hist_m[i] = hist_m[i-1];
      hist_m[0] = d;
      for (int i = 0; i < 8; i++) s += hist_m[i];
      exp_q.push_back(16'(s >> 3));
   endtask

   task automatic model_clear();
      exp_q.delete();
      for (int i = 0; i < 8; i++) hist_m[i] = 16'h0000;
   endtask

   // Drive one cycle's inputs at the falling edge and observe just after.
   task automatic clk_cycle(input logic v, input logic [15:0] d, input logic r,
                            output logic took, output logic [15:0] got,
                            output logic rdy, output logic acc);
      @(negedge aclk);
      s_valid = v;
      s_data  = d;
      m_ready = r;
      #1;
      rdy  = s_ready;
      took = m_valid && r;
      got  = m_data;
      acc  = v && s_ready;
      if (acc) model_push(d);
   endtask

   task automatic do_reset();
      @(negedge aclk);
      arstn   = 1'b0;
      s_valid = 1'b0;
      m_ready = 1'b1;
      model_clear();
      repeat (2) @(negedge aclk);
      arstn = 1'b1;
   endtask

   task automatic test_reset();
      #3;
      vectors++;
      if (m_valid !== 1'b0 || m_data !== 16'h0000 || s_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_state: valid=%b data=%h tready=%b, need 0/0000/1", m_valid, m_data, s_ready);
      end
      repeat (2) @(negedge aclk);
      arstn = 1'b1;
   endtask

   task automatic test_step();
      logic took, rdy, acc;
      logic [15:0] got, e;
      int idx = 0, n_out = 0;
      do_reset();
      for (int c = 0; c < 30; c++) begin
         clk_cycle(idx < 10, 16'h0800, 1'b1, took, got, rdy, acc);
         if (acc) idx++;
         if (took) begin
            vectors++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL step_extra: got %h, nothing expected", got);
            end else begin
               e = exp_q.pop_front();
               if (got !== e || (n_out < 10 && got !== step_tbl[n_out])) begin
                  fails++;
                  $display("FAIL step_out%0d: got %h, need %h", n_out, got, e);
               end
            end
            n_out++;
         end
      end
      vectors++;
      if (n_out != 10 || exp_q.size() != 0) begin
         fails++;
         $display("FAIL step_count: got %0d outputs, need 10", n_out);
      end
   endtask

   task automatic test_impulse();
      logic took, rdy, acc;
      logic [15:0] got, e;
      int idx = 0, n_out = 0;
      do_reset();
      for (int c = 0; c < 30; c++) begin
         clk_cycle(idx < 10, (idx == 0) ? 16'h0800 : 16'h0000, 1'b1, took, got, rdy, acc);
         if (acc) idx++;
         if (took) begin
            vectors++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
            if (got !== e || got !== ((n_out < 8) ? 16'h0100 : 16'h0000)) begin
               fails++;
               $display("FAIL impulse_out%0d: got %h, need %h", n_out, got, e);
            end
            n_out++;
         end
      end
      vectors++;
      if (n_out != 10) begin
         fails++;
         $display("FAIL impulse_count: got %0d outputs, need 10", n_out);
      end
   endtask

   task automatic test_full_scale();
      logic took, rdy, acc;
      logic [15:0] got, e;
      int idx = 0, n_out = 0;
      do_reset();
      for (int c = 0; c < 25; c++) begin
         clk_cycle(idx < 9, 16'hFFFF, 1'b1, took, got, rdy, acc);
         if (acc) idx++;
         if (took) begin
            vectors++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
            if (got !== e || (n_out == 0 && got !== 16'h1FFF) || (n_out >= 7 && got !== 16'hFFFF)) begin
               fails++;
               $display("FAIL fullscale_out%0d: got %h, need %h", n_out, got, e);
            end
            n_out++;
         end
      end
      vectors++;
      if (n_out != 9) begin
         fails++;
         $display("FAIL fullscale_count: got %0d outputs, need 9", n_out);
      end
   endtask

   task automatic test_backpressure();
      logic took, rdy, acc;
      logic [15:0] got, e, held;
      int idx = 0, n_out = 0;
      held = 16'h0000;
      do_reset();
      for (int c = 0; c < 35; c++) begin
         clk_cycle(idx < 10, 16'h0800, !(c >= 4 && c < 9), took, got, rdy, acc);
         if (acc) idx++;
         if (c == 4) held = got;
         if (c >= 4 && c < 9) begin
            vectors++;
            if (rdy !== 1'b0 || m_valid !== 1'b1 || got !== held) begin
               fails++;
               $display("FAIL bp_stall%0d: tready=%b valid=%b data=%h, need 0/1/%h", c, rdy, m_valid, got, held);
            end
         end
         if (took) begin
            vectors++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
            if (got !== e || (n_out < 10 && got !== step_tbl[n_out])) begin
               fails++;
               $display("FAIL bp_out%0d: got %h, need %h", n_out, got, e);
            end
            n_out++;
         end
      end
      vectors++;
      if (n_out != 10) begin
         fails++;
         $display("FAIL bp_count: got %0d outputs, need 10", n_out);
      end
   endtask

   task automatic test_gap();
      logic took, rdy, acc, v;
      logic [15:0] got, e;
      int idx = 0, n_out = 0;
      do_reset();
      for (int c = 0; c < 40; c++) begin
         v = (c % 2 == 0) && (idx < 10);
         clk_cycle(v, v ? 16'h0800 : 16'($urandom), 1'b1, took, got, rdy, acc);
         if (acc) idx++;
         if (took) begin
            vectors++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
            if (got !== e || (n_out < 10 && got !== step_tbl[n_out])) begin
               fails++;
               $display("FAIL gap_out%0d: got %h, need %h", n_out, got, e);
            end
            n_out++;
         end
      end
      vectors++;
      if (n_out != 10) begin
         fails++;
         $display("FAIL gap_count: got %0d outputs, need 10", n_out);
      end
   endtask

   task automatic test_back_to_back();
      logic took, rdy, acc;
      logic [15:0] got, e;
      do_reset();
      for (int c = 0; c < 25; c++) begin
         clk_cycle(c < 20, 16'($urandom), 1'b1, took, got, rdy, acc);
         vectors++;
         if (took !== (c >= 1 && c <= 20) || rdy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_flow%0d: took=%b tready=%b, need %b/1", c, took, rdy, (c >= 1 && c <= 20));
         end
         if (took) begin
            vectors++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
            if (got !== e) begin
               fails++;
               $display("FAIL b2b_out%0d: got %h, need %h", c, got, e);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      logic took, rdy, acc, pre_valid;
      logic [15:0] got, e;
      int n_out = 0;
      do_reset();
      for (int c = 0; c < 4; c++) begin
         clk_cycle(1'b1, 16'h0800, 1'b1, took, got, rdy, acc);
         if (took) begin
            vectors++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
            if (got !== e) begin
               fails++;
               $display("FAIL mrst_pre%0d: got %h, need %h", c, got, e);
            end
         end
      end
      @(negedge aclk);
      s_valid = 1'b0;
      #1;
      pre_valid = m_valid;
      arstn = 1'b0;
      #1;
      vectors++;
      if (pre_valid !== 1'b1 || m_valid !== 1'b0 || m_data !== 16'h0000 || s_ready !== 1'b1) begin
         fails++;
         $display("FAIL mrst_async: pre_valid=%b valid=%b data=%h tready=%b, need 1/0/0000/1",
                  pre_valid, m_valid, m_data, s_ready);
      end
      model_clear();
      repeat (2) @(negedge aclk);
      arstn = 1'b1;
      for (int c = 0; c < 6; c++) begin
         clk_cycle(c == 0, 16'h0800, 1'b1, took, got, rdy, acc);
         if (took) begin
            vectors++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
            if (got !== e || got !== 16'h0100) begin
               fails++;
               $display("FAIL mrst_first: got %h, need 0100", got);
            end
            n_out++;
         end
      end
      vectors++;
      if (n_out != 1) begin
         fails++;
         $display("FAIL mrst_count: got %0d outputs, need 1", n_out);
      end
   endtask

   initial begin
      arstn   = 1'b0;
      s_valid = 1'b0;
      s_data  = 16'h0000;
      m_ready = 1'b0;
      model_clear();
      test_reset();
      test_step();
      test_impulse();
      test_full_scale();
      test_backpressure();
      test_gap();
      test_back_to_back();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
